// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit field positions, route label codes and default flit width.
package noc_pkg;

   localparam int DATASIZE_DEFAULT = 40;

   localparam int SRC_MSB  = 39;
   localparam int SRC_LSB  = 36;
   localparam int DST_MSB  = 35;
   localparam int DST_LSB  = 32;
   localparam int TS_MSB   = 31;
   localparam int TS_LSB   = 24;
   localparam int DATA_MSB = 23;
   localparam int DATA_LSB = 2;
   localparam int TYPE_MSB = 1;
   localparam int TYPE_LSB = 0;

   localparam logic [3:0] LBL_NONE = 4'd0;
   localparam logic [3:0] LBL_L    = 4'd1;
   localparam logic [3:0] LBL_N    = 4'd2;
   localparam logic [3:0] LBL_E    = 4'd3;
   localparam logic [3:0] LBL_S    = 4'd4;
   localparam logic [3:0] LBL_W    = 4'd5;

endpackage

// File: rtl/input_port_unit_if.sv
// Link-side and allocator-side signals of one router input port.
interface input_port_unit_if #(
   parameter int DATASIZE = 40,
   parameter int WIDTH    = 3
);
   // A flit is accepted on a rising edge where data_in_valid=1 and full=0; otherwise the
   // sender holds it and retries. ready=1 on an edge consumes the presented head flit,
   // and is ignored while count==0.
   logic [DATASIZE-1:0] data_in;
   logic                data_in_valid;
   logic                full;
   logic                ready;
   logic [3:0]          label;
   logic [DATASIZE-1:0] data_out;
   logic [WIDTH:0]      count;

   modport master (
      output data_in, data_in_valid, ready,
      input  full, label, data_out, count
   );

   modport slave (
      input  data_in, data_in_valid, ready,
      output full, label, data_out, count
   );
endinterface

// File: rtl/route_compute.sv
// XY dimension-order route selection for a destination {dx, dy}; rows grow southward.
module route_compute
   import noc_pkg::*;
#(
   parameter int X_ID = 0,
   parameter int Y_ID = 0
) (
   input  logic [3:0] i_dst,
   output logic [3:0] o_label
);

   localparam logic [1:0] X_POS = 2'(X_ID);
   localparam logic [1:0] Y_POS = 2'(Y_ID);

   logic [1:0] w_dx;
   logic [1:0] w_dy;

   assign w_dx = i_dst[3:2];
   assign w_dy = i_dst[1:0];

   always_comb begin
      o_label = LBL_L;
      if (w_dx > X_POS)      o_label = LBL_E;
      else if (w_dx < X_POS) o_label = LBL_W;
      else if (w_dy > Y_POS) o_label = LBL_S;
      else if (w_dy < Y_POS) o_label = LBL_N;
   end

endmodule

// File: rtl/input_port_unit.sv
// Router input port: flit FIFO with XY route label computed from the head flit.
module input_port_unit
   import noc_pkg::*;
#(
   parameter int DEPTH    = 8,
   parameter int WIDTH    = 3,
   parameter int DATASIZE = DATASIZE_DEFAULT,
   parameter int X_ID     = 0,
   parameter int Y_ID     = 0
) (
   input logic               clk,
   input logic               rst_n,
   input_port_unit_if.slave  port
);

   localparam logic [WIDTH:0] FULL_COUNT = (WIDTH + 1)'(DEPTH);

   logic [DATASIZE-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0]    r_wr_ptr;
   logic [WIDTH-1:0]    r_rd_ptr;
   logic [WIDTH:0]      r_count;

   logic                w_full;
   logic                w_empty;
   logic                w_push;
   logic                w_pop;
   logic [DATASIZE-1:0] w_head;
   logic [3:0]          w_route;

   assign w_full  = (r_count == FULL_COUNT);
   assign w_empty = (r_count == '0);
   // Push qualifies on the registered full only, so a push is dropped while full even
   // when a pop frees a slot in the same cycle.
   assign w_push  = port.data_in_valid && !w_full;
   assign w_pop   = port.ready && !w_empty;
   assign w_head  = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= port.data_in;
            r_wr_ptr        <= r_wr_ptr + WIDTH'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + WIDTH'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (WIDTH + 1)'(1);
            2'b01:   r_count <= r_count - (WIDTH + 1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   route_compute #(
      .X_ID (X_ID),
      .Y_ID (Y_ID)
   ) u_route (
      .i_dst   (w_head[DST_MSB:DST_LSB]),
      .o_label (w_route)
   );

   assign port.full     = w_full;
   assign port.count    = r_count;
   assign port.data_out = w_empty ? '0 : w_head;
   assign port.label    = w_empty ? LBL_NONE : w_route;

endmodule

// File: tb/tb_input_port_unit.sv
// Directed bench for input_port_unit: stimulus pushes expected flits, a monitor checks each pop.
module tb_input_port_unit;

   logic clk;
   logic rst_n;

   input_port_unit_if #(.DATASIZE(40), .WIDTH(3)) pif ();
   input_port_unit_if #(.DATASIZE(40), .WIDTH(3)) pif_w ();

   input_port_unit #(
      .DEPTH(8), .WIDTH(3), .DATASIZE(40), .X_ID(0), .Y_ID(2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .port  (pif)
   );

   input_port_unit #(
      .DEPTH(8), .WIDTH(3), .DATASIZE(40), .X_ID(3), .Y_ID(1)
   ) dut_w (
      .clk   (clk),
      .rst_n (rst_n),
      .port  (pif_w)
   );

   int checks = 0;
   int errors = 0;
   int model_count = 0;
   logic [43:0] exp_q[$];

   logic [3:0] tdst [4];
   logic [3:0] tlbl [4];

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [39:0] mk(input logic [3:0] dst, input logic [7:0] n);
      return {n[3:0], dst, n, 14'h2AB5, n, n[1:0]};
   endfunction

   // driver: one clock cycle of stimulus; updates the occupancy model and expected queue
   task automatic cycle(input logic v, input logic [39:0] f, input logic [3:0] lbl,
                        input logic r, input logic rs);
      logic pu;
      logic po;
      rst_n             = rs;
      pif.data_in       = f;
      pif.data_in_valid = v;
      pif.ready         = r;
      pu = v && !rs && (model_count < 8);
      po = r && !rs && (model_count > 0);
      @(posedge clk);
      #1;
      if (rs) begin
         model_count = 0;
         exp_q.delete();
      end else begin
         if (pu) exp_q.push_back({lbl, f});
         model_count += int'(pu) - int'(po);
      end
      rst_n             = 1'b0;
      pif.data_in_valid = 1'b0;
      pif.ready         = 1'b0;
   endtask

   task automatic chk_state(input string tag);
      chk({tag, "_count"}, 64'(pif.count), 64'(model_count));
      chk({tag, "_full"}, 64'(pif.full), 64'(model_count == 8));
      if (exp_q.size() == 0) begin
         chk({tag, "_label"}, 64'(pif.label), 64'(0));
         chk({tag, "_data"}, 64'(pif.data_out), 64'(0));
      end else begin
         chk({tag, "_label"}, 64'(pif.label), 64'(exp_q[0][43:40]));
         chk({tag, "_data"}, 64'(pif.data_out), 64'(exp_q[0][39:0]));
      end
   endtask

   // scoreboard monitor: every consumed head flit must match the oldest expected entry
   always @(negedge clk) begin
      if (!rst_n && pif.ready && model_count != 0) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_unexpected: actual=%0h expected=none", pif.data_out);
         end else begin
            logic [43:0] e;
            e = exp_q.pop_front();
            chk("pop_data", 64'(pif.data_out), 64'(e[39:0]));
            chk("pop_label", 64'(pif.label), 64'(e[43:40]));
         end
      end
   end

   initial begin
      tdst[0] = 4'b0001; tlbl[0] = 4'd2;
      tdst[1] = 4'b0110; tlbl[1] = 4'd3;
      tdst[2] = 4'b0010; tlbl[2] = 4'd1;
      tdst[3] = 4'b0011; tlbl[3] = 4'd4;
      pif.data_in = '0; pif.data_in_valid = 1'b0; pif.ready = 1'b0;
      pif_w.data_in = '0; pif_w.data_in_valid = 1'b0; pif_w.ready = 1'b0;
      rst_n = 1'b1;

      cycle(1'b0, '0, 4'd0, 1'b0, 1'b1);
      cycle(1'b0, '0, 4'd0, 1'b0, 1'b1);
      chk("reset_count", 64'(pif.count), 64'(0));
      chk("reset_full", 64'(pif.full), 64'(0));
      chk("reset_label", 64'(pif.label), 64'(0));
      chk("reset_data", 64'(pif.data_out), 64'(0));

      // route labels at X_ID=0, Y_ID=2
      cycle(1'b1, mk(4'b0010, 8'h11), 4'd1, 1'b0, 1'b0);
      chk("route_L", 64'(pif.label), 64'(1));
      chk_state("push_L");
      cycle(1'b0, '0, 4'd0, 1'b1, 1'b0);
      cycle(1'b1, mk(4'b1110, 8'h22), 4'd3, 1'b0, 1'b0);
      chk("route_E", 64'(pif.label), 64'(3));
      cycle(1'b0, '0, 4'd0, 1'b1, 1'b0);
      cycle(1'b1, mk(4'b0011, 8'h33), 4'd4, 1'b0, 1'b0);
      chk("route_S", 64'(pif.label), 64'(4));
      cycle(1'b0, '0, 4'd0, 1'b1, 1'b0);
      cycle(1'b1, mk(4'b0000, 8'h44), 4'd2, 1'b0, 1'b0);
      chk("route_N", 64'(pif.label), 64'(2));
      cycle(1'b0, '0, 4'd0, 1'b1, 1'b0);
      chk_state("drained");

      // pop while empty
      cycle(1'b0, '0, 4'd0, 1'b1, 1'b0);
      chk_state("empty_pop");
      cycle(1'b1, mk(4'b0110, 8'h55), 4'd3, 1'b0, 1'b0);
      chk_state("after_empty_pop");
      cycle(1'b0, '0, 4'd0, 1'b1, 1'b0);

      // fill, dropped push, retry
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, mk(tdst[i % 4], 8'(8'h60 + i)), tlbl[i % 4], 1'b0, 1'b0);
      end
      chk_state("filled");
      cycle(1'b1, mk(tdst[1], 8'h70), tlbl[1], 1'b0, 1'b0);
      chk_state("drop_when_full");
      cycle(1'b0, '0, 4'd0, 1'b1, 1'b0);
      chk_state("pop_from_full");
      cycle(1'b1, mk(tdst[1], 8'h70), tlbl[1], 1'b0, 1'b0);
      chk_state("retry_accepted");
      cycle(1'b1, mk(tdst[2], 8'h71), tlbl[2], 1'b1, 1'b0);
      chk_state("full_push_pop");
      for (int i = 0; i < 7; i++) cycle(1'b0, '0, 4'd0, 1'b1, 1'b0);
      chk_state("fill_drained");

      // steady push+pop at occupancy 3
      for (int i = 0; i < 3; i++) cycle(1'b1, mk(tdst[i], 8'(8'h80 + i)), tlbl[i], 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, mk(tdst[(i + 3) % 4], 8'(8'h90 + i)), tlbl[(i + 3) % 4], 1'b1, 1'b0);
         chk_state("stream");
      end
      for (int i = 0; i < 3; i++) cycle(1'b0, '0, 4'd0, 1'b1, 1'b0);
      chk_state("stream_drained");

      // reset with buffered flits and a concurrent push
      for (int i = 0; i < 5; i++) cycle(1'b1, mk(tdst[i % 4], 8'(8'hA0 + i)), tlbl[i % 4], 1'b0, 1'b0);
      chk_state("pre_reset");
      cycle(1'b1, mk(tdst[0], 8'hAF), tlbl[0], 1'b0, 1'b1);
      chk_state("mid_reset");
      cycle(1'b1, mk(4'b0011, 8'hB0), 4'd4, 1'b0, 1'b0);
      chk_state("post_reset_push");
      cycle(1'b0, '0, 4'd0, 1'b1, 1'b0);
      chk_state("post_reset_drained");

      // west and other labels on a router at X_ID=3, Y_ID=1
      begin
         logic [3:0] wd [4];
         logic [3:0] wl [4];
         wd[0] = 4'b0101; wl[0] = 4'd5;
         wd[1] = 4'b1100; wl[1] = 4'd2;
         wd[2] = 4'b1110; wl[2] = 4'd4;
         wd[3] = 4'b1101; wl[3] = 4'd1;
         for (int i = 0; i < 4; i++) begin
            pif_w.data_in = mk(wd[i], 8'(8'hC0 + i));
            pif_w.data_in_valid = 1'b1;
            @(posedge clk); #1;
            pif_w.data_in_valid = 1'b0;
            chk("route_x3y1", 64'(pif_w.label), 64'(wl[i]));
            pif_w.ready = 1'b1;
            @(posedge clk); #1;
            pif_w.ready = 1'b0;
            chk("route_x3y1_empty", 64'(pif_w.label), 64'(0));
         end
      end

      chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/input_port_unit.md
# input_port_unit

Input buffering and route-computation stage for one router input port; sits directly upstream of the switch allocator. It accepts flits from a neighbouring router or the local PE into a DEPTH-entry FIFO and computes an XY-routing output label for the head flit. It presents the label and head flit to the allocator, and pops on the allocator's ready pulse.

## Interface
Parameters:
- DEPTH, 8, FIFO entries (power of two)
- WIDTH, 3, pointer width, log2(DEPTH)
- DATASIZE, 40, flit width: src[39:36], dst[35:32], timestamp[31:24], data[23:2], type[1:0]
- X_ID, 0, this router's column, 0..3
- Y_ID, 0, this router's row, 0..3

Ports:
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  reset, synchronous and active-high (rst_n=1 resets)
- data_in  input  DATASIZE  incoming flit from link
- data_in_valid  input  1  flit on data_in is valid
- full  output  1  FIFO cannot accept; upstream must not assert valid expecting acceptance
- ready  input  1  allocator consumed head flit this cycle (pop)
- label  output  4  route request for head flit; 0 when empty
- data_out  output  DATASIZE  head flit; 0 when empty
- count  output  WIDTH+1  current occupancy

## Operation
- Push: data_in_valid && !full writes data_in at wr_ptr; wr_ptr increments.
- Pop: ready && count!=0 advances rd_ptr. Ready while empty is ignored, and no state changes.
- Pointers are WIDTH bits and wrap naturally DEPTH-1 -> 0.
- count updates as +1 on push only, -1 on pop only, and unchanged on both or neither.
- full = (count == DEPTH) from the registered count. A push while full is dropped even if a pop occurs the same cycle; the upstream keeps its flit and retries.
- Push and pop in the same cycle with count between 1 and DEPTH-1 both take effect.
- Label encoding: 0 none, 1 L, 2 N, 3 E, 4 S, 5 W, other codes unused.
- Row index grows southward.
- Route computation is XY and purely combinational from head dst: dx=dst[35:34], dy=dst[33:32].
  - dx>X_ID gives E; dx<X_ID gives W.
  - Otherwise dy>Y_ID gives S; dy<Y_ID gives N.
  - Otherwise L.
- label and data_out are 0 whenever count==0.
- Flit contents, including timestamp, pass through unmodified.

## Timing
- Reset: wr_ptr=0, rd_ptr=0, count=0, full=0, label=0, data_out=0. Storage contents are don't-care.
- Reset mid-operation discards all buffered flits. A push or pop asserted during a reset cycle is ignored.
- Write-to-head latency is one cycle: a flit pushed into an empty FIFO at edge t appears on data_out/label after edge t.
- Pop is effective at the edge where ready=1. The next flit, or 0 if empty, appears after that edge.
- Back-to-back pops at one flit per cycle are supported.
- full rises on the edge making count==DEPTH and falls on the edge of the first pop.

## Structure
- Shared package noc_pkg holds:
  - flit field bit positions (SRC_MSB/LSB, DST, TS, DATA, TYPE)
  - label constants LBL_NONE, LBL_L, LBL_N, LBL_E, LBL_S, LBL_W
  - DATASIZE default
- One combinational sub-module, route_compute (inputs dst, X_ID/Y_ID parameters; output label), reused by every port instance.
- The FIFO is inline with a register array, with no separate module.

## Test plan
- Reset, then X_ID=0, Y_ID=2:
  - push dst=4'b0010 → after one edge label=1 (L), data_out matches, count=1.
  - push dst=4'b1110 → label=3 (E).
  - push dst=4'b0011 → label=4 (S).
- Fill: 8 consecutive pushes with no pops → full=1 after the 8th edge. A 9th push is dropped and count stays 8. A pop gives full=0 the next cycle, and the retried push is then accepted in FIFO order.
- Simultaneous push/pop at count=3 for 10 cycles → count stays 3, output order matches input order, and pointers wrap past 7 correctly.
- Pop while empty (ready=1, count=0) → count stays 0, label=0, data_out=0, and the pointers are unchanged.
- Reset asserted with count=5 and a push in the same cycle → count=0, full=0, label=0 on the next cycle, and the old flits are never presented.
- Push while full with a simultaneous pop → pop occurs, push is dropped, count=7.
